// File: rtl/shiftreg_pkg.sv
// Shared definitions for the serial configuration link.
// Holds the register-length defaults and the FSM state encoding used by both
// the receiving side (sr_cfg_receiver) and the transmitting FSM.
package shiftreg_pkg;

  localparam int unsigned SizeSrDynDefault  = 16;
  localparam int unsigned SizeSrStatDefault = 88;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StShiftDyn  = 2'd1,
    StShiftStat = 2'd2,
    StAbort     = 2'd3
  } sr_state_e;

endpackage

// File: rtl/sr_shadow.sv
// Shadow shift register with saturating bit counter.
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   clr        restart the frame; with shift_en the current bit becomes bit 1
//   shift_en   shift serial_in in at the LSB end (MSB-first framing)
//   serial_in  serial data bit
//   shadow     accumulated word
//   count      bits seen in this frame, saturating at SIZE+1
module sr_shadow #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned CNT_W = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [SIZE-1:0]  shadow,
  output logic [CNT_W-1:0] count
);

  // SIZE+1 is enough to tell an over-long frame apart from an exact one.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(SIZE + 1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow <= '0;
      count  <= '0;
    end else if (clr) begin
      shadow <= shift_en ? SIZE'(serial_in) : '0;
      count  <= shift_en ? CNT_W'(1) : '0;
    end else if (shift_en) begin
      shadow <= {shadow[SIZE-2:0], serial_in};
      if (count != CntMax) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sr_cfg_receiver.sv
// Serial configuration receiver.
// Accepts MSB-first frames for a dynamic and a static configuration register.
// A frame is committed only if exactly the register length was shifted in;
// short, long or colliding frames are rejected with a len_err pulse.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   sel_dyn, sel_stat   frame selects
//   signal_in           serial data
//   en_fin              sender acknowledges the dynamic load
//   dyn_cfg, stat_cfg   last accepted words
//   dyn_valid, stat_valid, len_err   one-cycle result pulses
//   cfg_ready           dynamic config loaded and acknowledged
//   busy                receiver not idle
module sr_cfg_receiver
  import shiftreg_pkg::*;
#(
  parameter int unsigned SIZESRDYN  = SizeSrDynDefault,
  parameter int unsigned SIZESRSTAT = SizeSrStatDefault
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  sel_dyn,
  input  logic                  sel_stat,
  input  logic                  signal_in,
  input  logic                  en_fin,
  output logic [SIZESRDYN-1:0]  dyn_cfg,
  output logic [SIZESRSTAT-1:0] stat_cfg,
  output logic                  dyn_valid,
  output logic                  stat_valid,
  output logic                  len_err,
  output logic                  cfg_ready,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(SIZESRSTAT + 2);

  sr_state_e state_q, state_d;

  logic [SIZESRDYN-1:0]  dyn_shadow;
  logic [SIZESRSTAT-1:0] stat_shadow;
  logic [CntW-1:0]       dyn_cnt, stat_cnt;
  logic                  dyn_clr, dyn_shift, stat_clr, stat_shift;
  logic                  dyn_valid_d, stat_valid_d, len_err_d, cfg_ready_d;
  logic                  dyn_seen_q;

  sr_shadow #(
    .SIZE  (SIZESRDYN),
    .CNT_W (CntW)
  ) u_dyn_shadow (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (dyn_clr),
    .shift_en  (dyn_shift),
    .serial_in (signal_in),
    .shadow    (dyn_shadow),
    .count     (dyn_cnt)
  );

  sr_shadow #(
    .SIZE  (SIZESRSTAT),
    .CNT_W (CntW)
  ) u_stat_shadow (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (stat_clr),
    .shift_en  (stat_shift),
    .serial_in (signal_in),
    .shadow    (stat_shadow),
    .count     (stat_cnt)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (sel_dyn && sel_stat) begin
          state_d = StAbort;
        end else if (sel_dyn) begin
          state_d = StShiftDyn;
        end else if (sel_stat) begin
          state_d = StShiftStat;
        end
      end
      StShiftDyn: begin
        if (sel_stat) begin
          state_d = StAbort;
        end else if (!sel_dyn) begin
          state_d = StIdle;
        end
      end
      StShiftStat: begin
        if (sel_dyn) begin
          state_d = StAbort;
        end else if (!sel_stat) begin
          state_d = StIdle;
        end
      end
      StAbort: begin
        if (!sel_dyn && !sel_stat) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath control.
  always_comb begin
    dyn_valid_d  = 1'b0;
    stat_valid_d = 1'b0;
    len_err_d    = 1'b0;
    // Entry from IDLE captures the current bit as bit 1.
    dyn_clr      = (state_q == StIdle) && sel_dyn && !sel_stat;
    stat_clr     = (state_q == StIdle) && sel_stat && !sel_dyn;
    dyn_shift    = dyn_clr || ((state_q == StShiftDyn) && sel_dyn && !sel_stat);
    stat_shift   = stat_clr || ((state_q == StShiftStat) && sel_stat && !sel_dyn);
    unique case (state_q)
      StIdle: begin
        len_err_d = sel_dyn && sel_stat;
      end
      StShiftDyn: begin
        if (sel_stat) begin
          len_err_d = 1'b1;
        end else if (!sel_dyn) begin
          dyn_valid_d = (dyn_cnt == CntW'(SIZESRDYN));
          len_err_d   = (dyn_cnt != CntW'(SIZESRDYN));
        end
      end
      StShiftStat: begin
        if (sel_dyn) begin
          len_err_d = 1'b1;
        end else if (!sel_stat) begin
          stat_valid_d = (stat_cnt == CntW'(SIZESRSTAT));
          len_err_d    = (stat_cnt != CntW'(SIZESRSTAT));
        end
      end
      default: ;
    endcase

    // Acknowledge wins over the clear from a new dynamic frame.
    if (en_fin && dyn_seen_q) begin
      cfg_ready_d = 1'b1;
    end else if (dyn_clr) begin
      cfg_ready_d = 1'b0;
    end else begin
      cfg_ready_d = cfg_ready;
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dyn_cfg    <= '0;
      stat_cfg   <= '0;
      dyn_valid  <= 1'b0;
      stat_valid <= 1'b0;
      len_err    <= 1'b0;
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
      dyn_seen_q <= 1'b0;
    end else begin
      if (dyn_valid_d) begin
        dyn_cfg <= dyn_shadow;
      end
      if (stat_valid_d) begin
        stat_cfg <= stat_shadow;
      end
      dyn_valid  <= dyn_valid_d;
      stat_valid <= stat_valid_d;
      len_err    <= len_err_d;
      cfg_ready  <= cfg_ready_d;
      busy       <= (state_d != StIdle);
      dyn_seen_q <= dyn_seen_q | dyn_valid_d;
    end
  end

endmodule

// File: doc/sr_cfg_receiver.md
SR_CFG_RECEIVER -- requirements
Module: sr_cfg_receiver

Interface
REQ-001 SHALL have parameter SIZESRDYN, default 16, dynamic register length in bits.
REQ-002 SHALL have parameter SIZESRSTAT, default 88, static register length in bits.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high; one clock, no other clock domain.
REQ-005 SHALL have port sel_dyn  input  1  frame select, dynamic register.
REQ-006 SHALL have port sel_stat  input  1  frame select, static register.
REQ-007 SHALL have port signal_in  input  1  serial data, MSB first, sampled only while its select is high.
REQ-008 SHALL have port en_fin  input  1  sender indication that the dynamic load is complete.
REQ-009 SHALL have port dyn_cfg  output  SIZESRDYN  last accepted dynamic word.
REQ-010 SHALL have port stat_cfg  output  SIZESRSTAT  last accepted static word.
REQ-011 SHALL have port dyn_valid  output  1  one-cycle pulse, dyn_cfg updated.
REQ-012 SHALL have port stat_valid  output  1  one-cycle pulse, stat_cfg updated.
REQ-013 SHALL have port len_err  output  1  one-cycle pulse, frame rejected.
REQ-014 SHALL have port cfg_ready  output  1  level; dynamic config loaded and acknowledged by en_fin.
REQ-015 SHALL have port busy  output  1  level; high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT_DYN, SHIFT_STAT, ABORT; all outputs registered.
REQ-017 IDLE: sel_dyn=1,sel_stat=0 -> SHIFT_DYN; sel_stat=1,sel_dyn=0 -> SHIFT_STAT. In both cases the bit on signal_in is captured on that same edge, which counts as bit 1.
REQ-018 IDLE with both selects high SHALL go to ABORT and pulse len_err; no bit captured.
REQ-019 SHIFT_x, select high: shadow <= {shadow[SIZE-2:0], signal_in}; bit counter increments, saturating at SIZE+1. Counter width is clog2(SIZESRSTAT+2).
REQ-020 SHIFT_x, own select low, other low: go to IDLE. If count==SIZE, the target register takes the shadow and its valid pulses for one cycle. Both take effect on the edge that samples the select low. Otherwise len_err pulses and the target register is unchanged.
REQ-021 SHIFT_x with the other select high (regardless of own) SHALL go to ABORT, pulse len_err, and leave both registers unchanged.
REQ-022 ABORT SHALL stay until both selects are sampled low, then go to IDLE; input bits are ignored.
REQ-023 Shadow and counter SHALL clear on every entry to a SHIFT state; the dynamic and static shadows are separate.
REQ-024 cfg_ready SHALL set on any edge where en_fin=1 and at least one dyn_valid has occurred since reset. It SHALL clear on entry to SHIFT_DYN; set takes priority if both occur on the same edge.
REQ-025 dyn_valid, stat_valid and len_err SHALL be mutually exclusive in any cycle.
REQ-026 Back-to-back frames (select low for exactly one cycle between them) SHALL both be accepted.

Reset
REQ-027 RST high SHALL immediately force: state IDLE, dyn_cfg=0, stat_cfg=0, all shadows/counters 0, dyn_valid=stat_valid=len_err=cfg_ready=busy=0.
REQ-028 A frame interrupted by RST SHALL be discarded; after RST release, reception SHALL restart only from IDLE detection of a select.

Structure
REQ-029 Shared package shiftreg_pkg SHALL hold the FSM state encoding and the SIZESRDYN/SIZESRSTAT defaults, shared with the transmitting FSM.
REQ-030 One sub-module sr_shadow (parameter SIZE; clear, shift enable, serial in; outputs shadow word and saturating count) SHALL be instantiated twice.

Verification
REQ-031 Reset, then sel_dyn high for 16 cycles with 0x8001 MSB first -> dyn_cfg=0x8001, dyn_valid for 1 cycle on the edge sampling sel_dyn=0, len_err=0.
REQ-032 Load 0x8001, then a 15-bit dynamic frame -> len_err 1 cycle, dyn_cfg stays 0x8001; repeat with a 17-bit frame -> same.
REQ-033 88-bit static frame of alternating 1/0 starting with 1 -> stat_cfg = 0xAAAA...AA (88 bits), stat_valid 1 cycle.
REQ-034 sel_stat raised at bit 8 of a dynamic frame -> len_err 1 cycle, ABORT until both selects are low, no register change, then a valid frame is accepted.
REQ-035 Valid dyn load, then en_fin=1 -> cfg_ready=1 next cycle; a new sel_dyn -> cfg_ready=0; en_fin before any load -> cfg_ready stays 0.
REQ-036 RST pulsed mid-static-frame (bit 40) -> all outputs 0 asynchronously; the remaining bits are ignored until the next select rises from IDLE.
